// File: rtl/sumator_arbiter_if.sv
// rtl/sumator_arbiter_if.sv - requester and response handshake bundle for sumator_arbiter
interface sumator_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;

  modport master (
    output req0_valid, req0_a, req0_b, input req0_ready,
    output req1_valid, req1_a, req1_b, input req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, output req0_ready,
    input  req1_valid, req1_a, req1_b, output req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, input rsp_ready
  );
endinterface

// File: rtl/sumator_arbiter.sv
// rtl/sumator_arbiter.sv - two-requester arbiter sharing one combinational adder
module sumator_arbiter #(
  parameter int WIDTH = 4,
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  sumator_arbiter_if.slave bus,
  output logic [WIDTH-1:0] add_i1,
  output logic [WIDTH-1:0] add_i2,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             sel1;
  logic             gnt0;
  logic             gnt1;
  logic             accept;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_cout_q;

  // req1 wins only when alone, or on a round-robin tie after req0 was last served
  always_comb begin
    sel1 = bus.req1_valid && (!bus.req0_valid || (RR_EN && !last_grant));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is gated by rst_n so the grant stays low for the whole reset window
  always_comb begin
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    if ((state == IDLE) && rst_n) begin
      gnt0 = bus.req0_valid && !sel1;
      gnt1 = sel1;
    end
    accept         = gnt0 || gnt1;
    bus.req0_ready = gnt0;
    bus.req1_ready = gnt1;
    bus.rsp_valid  = (state == RESP);
    busy           = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_i1     <= '0;
      add_i2     <= '0;
      rsp_id_q   <= 1'b0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        add_i1     <= gnt1 ? bus.req1_a : bus.req0_a;
        add_i2     <= gnt1 ? bus.req1_b : bus.req0_b;
        rsp_id_q   <= gnt1;
        last_grant <= gnt1;
      end
      // The adder has had a full cycle to settle on the registered operands
      if (state == ISSUE) begin
        rsp_sum_q  <= add_sum;
        rsp_cout_q <= add_cout;
      end
    end
  end

  assign bus.rsp_id   = rsp_id_q;
  assign bus.rsp_sum  = rsp_sum_q;
  assign bus.rsp_cout = rsp_cout_q;

endmodule

// File: tb/tb_sumator_arbiter.sv
// tb/tb_sumator_arbiter.sv - directed self-checking bench for sumator_arbiter
module tb_sumator_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       t_v0, t_v1, t_rr;
  logic [3:0] t_a0, t_b0, t_a1, t_b1;
  int         errors = 0;
  int         checks = 0;
  logic       seen1;

  always #5 clk = ~clk;

  sumator_arbiter_if #(.WIDTH(4)) ifa ();
  sumator_arbiter_if #(.WIDTH(4)) ifb ();

  logic [3:0] a_i1, a_i2, a_sum, b_i1, b_i2, b_sum;
  logic       a_cout, b_cout, a_busy, b_busy;

  assign {a_cout, a_sum} = {1'b0, a_i1} + {1'b0, a_i2};
  assign {b_cout, b_sum} = {1'b0, b_i1} + {1'b0, b_i2};

  assign ifa.req0_valid = !sel && t_v0;
  assign ifa.req1_valid = !sel && t_v1;
  assign ifa.req0_a     = t_a0;
  assign ifa.req0_b     = t_b0;
  assign ifa.req1_a     = t_a1;
  assign ifa.req1_b     = t_b1;
  assign ifa.rsp_ready  = !sel && t_rr;
  assign ifb.req0_valid = sel && t_v0;
  assign ifb.req1_valid = sel && t_v1;
  assign ifb.req0_a     = t_a0;
  assign ifb.req0_b     = t_b0;
  assign ifb.req1_a     = t_a1;
  assign ifb.req1_b     = t_b1;
  assign ifb.rsp_ready  = sel && t_rr;

  sumator_arbiter #(.WIDTH(4), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(ifa),
    .add_i1(a_i1), .add_i2(a_i2), .add_sum(a_sum), .add_cout(a_cout), .busy(a_busy)
  );

  sumator_arbiter #(.WIDTH(4), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(ifb),
    .add_i1(b_i1), .add_i2(b_i2), .add_sum(b_sum), .add_cout(b_cout), .busy(b_busy)
  );

  logic       o_r0, o_r1, o_rv, o_id, o_cout, o_busy;
  logic [3:0] o_sum, o_i1, o_i2;

  always_comb begin
    o_r0   = sel ? ifb.req0_ready : ifa.req0_ready;
    o_r1   = sel ? ifb.req1_ready : ifa.req1_ready;
    o_rv   = sel ? ifb.rsp_valid  : ifa.rsp_valid;
    o_id   = sel ? ifb.rsp_id     : ifa.rsp_id;
    o_sum  = sel ? ifb.rsp_sum    : ifa.rsp_sum;
    o_cout = sel ? ifb.rsp_cout   : ifa.rsp_cout;
    o_busy = sel ? b_busy         : a_busy;
    o_i1   = sel ? b_i1           : a_i1;
    o_i2   = sel ? b_i2           : a_i2;
  end

  always @(posedge clk) begin
    if (ifb.req1_ready) seen1 <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE
  task automatic txn(input string tag, input logic v0, input logic v1,
                     input logic [3:0] a0, input logic [3:0] b0,
                     input logic [3:0] a1, input logic [3:0] b1,
                     input logic eid, input logic [3:0] esum, input logic ecout,
                     input logic keep, input int hold);
    t_v0 = v0; t_v1 = v1; t_a0 = a0; t_b0 = b0; t_a1 = a1; t_b1 = b1; t_rr = 1'b0;
    #1;
    check({tag, ".ready0"}, o_r0, v0 && (eid == 1'b0));
    check({tag, ".ready1"}, o_r1, v1 && (eid == 1'b1));
    check({tag, ".idle_busy"}, o_busy, 0);
    @(negedge clk);
    if (!keep) begin t_v0 = 1'b0; t_v1 = 1'b0; end
    #1;
    check({tag, ".issue_busy"}, o_busy, 1);
    check({tag, ".issue_valid"}, o_rv, 0);
    check({tag, ".issue_ready"}, {o_r0, o_r1}, 0);
    check({tag, ".add_i1"}, o_i1, eid ? a1 : a0);
    check({tag, ".add_i2"}, o_i2, eid ? b1 : b0);
    @(negedge clk);
    for (int i = 0; i <= hold; i++) begin
      check({tag, ".rsp_valid"}, o_rv, 1);
      check({tag, ".rsp_id"}, o_id, eid);
      check({tag, ".rsp_sum"}, o_sum, esum);
      check({tag, ".rsp_cout"}, o_cout, ecout);
      check({tag, ".resp_busy"}, o_busy, 1);
      check({tag, ".resp_ready"}, {o_r0, o_r1}, 0);
      if (i < hold) @(negedge clk);
    end
    t_rr = 1'b1;
    @(negedge clk);
    t_rr = 1'b0;
    #1;
    check({tag, ".rsp_drop"}, o_rv, 0);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; seen1 = 1'b0;
    t_v0 = 1'b1; t_v1 = 1'b0; t_rr = 1'b0;
    t_a0 = 4'd0; t_b0 = 4'd0; t_a1 = 4'd0; t_b1 = 4'd0;
    #2;
    check("rst.busy", a_busy, 0);
    check("rst.rsp_valid", ifa.rsp_valid, 0);
    check("rst.ready0", ifa.req0_ready, 0);
    check("rst.add_i1", a_i1, 0);
    check("rst.add_i2", a_i2, 0);
    check("rst.rsp_sum", ifa.rsp_sum, 0);
    check("rst.rsp_cout", ifa.rsp_cout, 0);
    check("rst.rsp_id", ifa.rsp_id, 0);
    t_v0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    txn("r0_12_14", 1, 0, 4'd12, 4'd14, 4'd0, 4'd0, 0, 4'd10, 1, 0, 0);
    txn("r1_10_9",  0, 1, 4'd0, 4'd0, 4'd10, 4'd9, 1, 4'd3, 1, 0, 0);
    txn("r0_8_6",   1, 0, 4'd8, 4'd6, 4'd0, 4'd0, 0, 4'd14, 0, 0, 0);
    txn("bp_7_8",   0, 1, 4'd0, 4'd0, 4'd7, 4'd8, 1, 4'd15, 0, 0, 5);

    // Drop a pair while it sits in ISSUE
    t_v0 = 1'b1; t_a0 = 4'd3; t_b0 = 4'd4;
    @(negedge clk);
    t_v0 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst.busy", a_busy, 0);
    check("midrst.rsp_valid", ifa.rsp_valid, 0);
    check("midrst.add_i1", a_i1, 0);
    check("midrst.rsp_sum", ifa.rsp_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst.no_rsp", ifa.rsp_valid, 0);
    end
    txn("r0_15_1", 1, 0, 4'd15, 4'd1, 4'd0, 4'd0, 0, 4'd0, 1, 0, 0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn("tie1", 1, 1, 4'd5, 4'd6, 4'd9, 4'd9, 0, 4'd11, 0, 1, 0);
    txn("tie2", 1, 1, 4'd5, 4'd6, 4'd9, 4'd9, 1, 4'd2,  1, 1, 0);
    txn("tie3", 1, 1, 4'd5, 4'd6, 4'd9, 4'd9, 0, 4'd11, 0, 1, 0);
    txn("tie4", 1, 1, 4'd5, 4'd6, 4'd9, 4'd9, 1, 4'd2,  1, 1, 0);
    t_v0 = 1'b0; t_v1 = 1'b0;
    @(negedge clk);

    sel = 1'b1;
    seen1 = 1'b0;
    @(negedge clk);
    txn("fp1", 1, 1, 4'd1, 4'd2, 4'd15, 4'd15, 0, 4'd3, 0, 1, 0);
    txn("fp2", 1, 1, 4'd1, 4'd2, 4'd15, 4'd15, 0, 4'd3, 0, 1, 0);
    txn("fp3", 1, 1, 4'd1, 4'd2, 4'd15, 4'd15, 0, 4'd3, 0, 1, 0);
    t_v0 = 1'b0; t_v1 = 1'b0;
    @(negedge clk);
    check("fp.req1_never_ready", seen1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
